// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter that shares one memory port between
// instruction fetch (IF) and data memory (DM).
// The IDLE -> BUSY -> RESP cycle gives a minimum of three cycles per transaction.
// A busy phase with no mem_done for TIMEOUT cycles locks the block in ERR until rst.
// Optional feature: define MEM_ARB_RR_EN to break IF/DM ties round-robin.
// Without it, DM always wins a tie.
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic        halt,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        if_done,
    output logic        dm_done,
    output logic [15:0] if_data,
    output logic [15:0] dm_rdata,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_IF,
        S_BUSY_DM,
        S_RESP,
        S_ERR
    } state_t;

    // Wait-counter value during the last busy cycle that may still complete.
    localparam logic [3:0] LP_LAST_BUSY = 4'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic        w_busy;
    logic        w_timeout;
    logic        w_if_ok;
    logic        w_grant_if;
    logic        w_grant_dm;
    logic        w_mem_en_nxt;
    logic        w_if_done_nxt;
    logic        w_dm_done_nxt;
    logic        w_err_nxt;

    logic        r_mem_en;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_if_done;
    logic        r_dm_done;
    logic [15:0] r_if_data;
    logic [15:0] r_dm_rdata;
    logic        r_err;

`ifdef MEM_ARB_RR_EN
    // Set when DM received the most recent grant. Reset value means IF was served last.
    logic        r_last_dm;
`endif

    assign w_busy    = (r_state == S_BUSY_IF) || (r_state == S_BUSY_DM);
    assign w_timeout = (r_wait_cnt == LP_LAST_BUSY);
    assign w_if_ok   = if_req && !halt;

    // Grant decision; only IDLE samples requests, so RESP gives a one-cycle bubble.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        if (r_state == S_IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (dm_req && w_if_ok) begin
                w_grant_dm = !r_last_dm;
                w_grant_if = r_last_dm;
            end else begin
                w_grant_dm = dm_req;
                w_grant_if = w_if_ok;
            end
`else
            w_grant_dm = dm_req;
            w_grant_if = w_if_ok && !dm_req;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic. mem_done is ignored outside the busy states.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_dm)      w_state_nxt = S_BUSY_DM;
                else if (w_grant_if) w_state_nxt = S_BUSY_IF;
            end
            S_BUSY_IF, S_BUSY_DM: begin
                if (mem_done)       w_state_nxt = S_RESP;
                else if (w_timeout) w_state_nxt = S_ERR;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered control outputs.
    always_comb begin
        w_mem_en_nxt  = w_grant_if || w_grant_dm;
        w_if_done_nxt = (r_state == S_BUSY_IF) && mem_done;
        w_dm_done_nxt = (r_state == S_BUSY_DM) && mem_done;
        w_err_nxt     = r_err || (w_busy && !mem_done && w_timeout);
    end

    // Wait counter: cleared on grant, counts busy cycles that end without mem_done.
    always_ff @(posedge clk) begin
        if (rst)                          r_wait_cnt <= 4'd0;
        else if (w_grant_if || w_grant_dm) r_wait_cnt <= 4'd0;
        else if (w_busy && !mem_done)     r_wait_cnt <= r_wait_cnt + 4'd1;
    end

`ifdef MEM_ARB_RR_EN
    // Remember which requester was granted last, for round-robin tie breaking.
    always_ff @(posedge clk) begin
        if (rst)             r_last_dm <= 1'b0;
        else if (w_grant_dm) r_last_dm <= 1'b1;
        else if (w_grant_if) r_last_dm <= 1'b0;
    end
`endif

    // Output registers. The transaction fields are latched on grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_if_data   <= 16'h0000;
            r_dm_rdata  <= 16'h0000;
            r_err       <= 1'b0;
        end else begin
            r_mem_en  <= w_mem_en_nxt;
            r_if_done <= w_if_done_nxt;
            r_dm_done <= w_dm_done_nxt;
            r_err     <= w_err_nxt;
            if (w_grant_dm) begin
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
                r_mem_wr    <= dm_wr;
            end else if (w_grant_if) begin
                r_mem_addr <= if_addr;
                r_mem_wr   <= 1'b0;
            end
            if (w_if_done_nxt)              r_if_data  <= mem_rdata;
            if (w_dm_done_nxt && !r_mem_wr) r_dm_rdata <= mem_rdata;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_done   = r_if_done;
    assign dm_done   = r_dm_done;
    assign if_data   = r_if_data;
    assign dm_rdata  = r_dm_rdata;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (TIMEOUT = 4).
// The stimulus pushes the expected issue and completion records.
// A negedge monitor pops those records and compares them whenever mem_en or a done pulse appears.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        halt;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        if_done;
    logic        dm_done;
    logic [15:0] if_data;
    logic [15:0] dm_rdata;
    logic        err;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .halt      (halt),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .if_done   (if_done),
        .dm_done   (dm_done),
        .if_data   (if_data),
        .dm_rdata  (dm_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_dm;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_if_data;
        logic [15:0] exp_dm_rdata;
    } txn_t;

    txn_t        q_issue[$];
    txn_t        q_cmpl[$];
    int          n_vec   = 0;
    int          n_bad   = 0;
    int          n_issue = 0;
    int          n_done  = 0;
    logic        prev_en = 1'b0;
    logic [15:0] m_if_data  = 16'h0000;
    logic [15:0] m_dm_rdata = 16'h0000;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Build an expected transaction. The data-register model is updated in service order.
    task automatic push_txn(input bit is_dm, input bit wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rdata,
                            input bit with_cmpl);
        txn_t t;
        if (with_cmpl) begin
            if (!is_dm)  m_if_data  = rdata;
            else if (!wr) m_dm_rdata = rdata;
        end
        t.is_dm        = is_dm;
        t.wr           = is_dm ? wr : 1'b0;
        t.addr         = addr;
        t.wdata        = wdata;
        t.exp_if_data  = m_if_data;
        t.exp_dm_rdata = m_dm_rdata;
        q_issue.push_back(t);
        if (with_cmpl) q_cmpl.push_back(t);
    endtask

    // Monitor: compares against the scoreboard whenever the DUT issues or completes.
    always @(negedge clk) begin
        txn_t t;
        if (prev_en) check("mem_en_one_cycle", {15'h0, mem_en}, 16'h0);
        prev_en <= mem_en;
        if (mem_en) begin
            n_issue++;
            if (q_issue.size() == 0) begin
                check("mem_en_unexpected", {15'h0, mem_en}, 16'h0);
            end else begin
                t = q_issue.pop_front();
                check("issue_addr", mem_addr, t.addr);
                check("issue_wr", {15'h0, mem_wr}, {15'h0, t.wr});
                if (t.wr) check("issue_wdata", mem_wdata, t.wdata);
            end
        end
        if (if_done || dm_done) begin
            n_done++;
            if (q_cmpl.size() == 0) begin
                check("done_unexpected", {14'h0, if_done, dm_done}, 16'h0);
            end else begin
                t = q_cmpl.pop_front();
                check("done_kind", {14'h0, if_done, dm_done}, t.is_dm ? 16'h1 : 16'h2);
                check("if_data", if_data, t.exp_if_data);
                check("dm_rdata", dm_rdata, t.exp_dm_rdata);
                check("resp_addr_held", mem_addr, t.addr);
                check("resp_wr_held", {15'h0, mem_wr}, {15'h0, t.wr});
            end
        end
    end

    // Wait (bounded) for mem_en. Returns the number of negedges that elapsed.
    task automatic wait_en(output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < 30) begin
            @(negedge clk);
            cycles++;
            if (mem_en) ok = 1'b1;
        end
        if (!ok) check("mem_en_wait_expired", {15'h0, mem_en}, 16'h1);
    endtask

    // Serve one granted transaction. mem_done arrives in busy cycle 'lat'.
    // The requester drops its request in the RESP cycle.
    task automatic serve(input bit is_dm, input logic [15:0] rdata, input int lat,
                         input bit halt_mid, output int gap);
        wait_en(gap);
        if (halt_mid) halt = 1'b1;
        if (lat > 0) begin
            repeat (lat) @(posedge clk);
            #1;
        end
        mem_done  = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_done  = 1'b0;
        mem_rdata = 16'h0000;
        if (is_dm) dm_req = 1'b0;
        else       if_req = 1'b0;
        if (halt_mid) halt = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"},    {15'h0, mem_en},  16'h0);
        check({tag, "_mem_wr"},    {15'h0, mem_wr},  16'h0);
        check({tag, "_mem_addr"},  mem_addr,         16'h0);
        check({tag, "_mem_wdata"}, mem_wdata,        16'h0);
        check({tag, "_dones"},     {14'h0, if_done, dm_done}, 16'h0);
        check({tag, "_if_data"},   if_data,          16'h0);
        check({tag, "_dm_rdata"},  dm_rdata,         16'h0);
        check({tag, "_err"},       {15'h0, err},     16'h0);
    endtask

    initial begin
        int gap;
        int issue0;
        int done0;
        rst = 1'b1; if_req = 1'b0; if_addr = 16'h0; dm_req = 1'b0; dm_wr = 1'b0;
        dm_addr = 16'h0; dm_wdata = 16'h0; halt = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // DM read. Loads dm_rdata, and mem_done arrives in busy cycle 0.
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200;
        push_txn(1'b1, 1'b0, 16'h0200, 16'h0, 16'h1111, 1'b1);
        serve(1'b1, 16'h1111, 0, 1'b0, gap);

        // Basic fetch. mem_done arrives in busy cycle 1.
        if_req = 1'b1; if_addr = 16'h0040;
        push_txn(1'b0, 1'b0, 16'h0040, 16'h0, 16'hD123, 1'b1);
        serve(1'b0, 16'hD123, 1, 1'b0, gap);

        // Tie: DM write wins (IF was served last, so round-robin also picks DM).
        // dm_rdata stays 0x1111, and the fetch follows after RESP plus IDLE.
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
        if_req = 1'b1; if_addr = 16'h0042;
        push_txn(1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0, 1'b1);
        push_txn(1'b0, 1'b0, 16'h0042, 16'h0, 16'h2222, 1'b1);
        serve(1'b1, 16'hAAAA, 0, 1'b0, gap);
        serve(1'b0, 16'h2222, 2, 1'b0, gap);
        check("tie_fetch_gap", 16'(gap), 16'd3);

        // DM-only read, so DM is now the last-served requester.
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300;
        push_txn(1'b1, 1'b0, 16'h0300, 16'h0, 16'h3333, 1'b1);
        serve(1'b1, 16'h3333, 1, 1'b0, gap);

        // Second tie: fixed priority picks DM; round-robin picks IF.
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0302;
        if_req = 1'b1; if_addr = 16'h0044;
`ifdef MEM_ARB_RR_EN
        push_txn(1'b0, 1'b0, 16'h0044, 16'h0, 16'h4545, 1'b1);
        push_txn(1'b1, 1'b0, 16'h0302, 16'h0, 16'h3434, 1'b1);
        serve(1'b0, 16'h4545, 1, 1'b0, gap);
        serve(1'b1, 16'h3434, 1, 1'b0, gap);
`else
        push_txn(1'b1, 1'b0, 16'h0302, 16'h0, 16'h3434, 1'b1);
        push_txn(1'b0, 1'b0, 16'h0044, 16'h0, 16'h4545, 1'b1);
        serve(1'b1, 16'h3434, 1, 1'b0, gap);
        serve(1'b0, 16'h4545, 1, 1'b0, gap);
`endif
        check("tie2_second_gap", 16'(gap), 16'd3);

        // Halt blocks fetch grants, while a DM read during halt is still served.
        halt = 1'b1; if_req = 1'b1; if_addr = 16'h0050;
        issue0 = n_issue;
        repeat (20) @(posedge clk); #1;
        check("halt_no_fetch", 16'(n_issue), 16'(issue0));
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0400;
        push_txn(1'b1, 1'b0, 16'h0400, 16'h0, 16'h4444, 1'b1);
        serve(1'b1, 16'h4444, 1, 1'b0, gap);
        repeat (5) @(posedge clk); #1;
        check("halt_only_dm_issued", 16'(n_issue), 16'(issue0 + 1));
        halt = 1'b0;
        push_txn(1'b0, 1'b0, 16'h0050, 16'h0, 16'h5050, 1'b1);
        serve(1'b0, 16'h5050, 1, 1'b0, gap);

        // Halt rising during BUSY_IF does not abort the fetch.
        if_req = 1'b1; if_addr = 16'h0060;
        push_txn(1'b0, 1'b0, 16'h0060, 16'h0, 16'h6060, 1'b1);
        serve(1'b0, 16'h6060, 2, 1'b1, gap);

        // mem_done in the last allowed busy cycle (TIMEOUT-1 = 3) still completes.
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0070; dm_wdata = 16'h7777;
        push_txn(1'b1, 1'b1, 16'h0070, 16'h7777, 16'h0, 1'b1);
        serve(1'b1, 16'h9999, 3, 1'b0, gap);
        check("late_done_no_err", {15'h0, err}, 16'h0);

        // Reset in busy cycle 1 of a DM read, then a stray mem_done in the next cycle.
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500;
        push_txn(1'b1, 1'b0, 16'h0500, 16'h0, 16'h0, 1'b0);
        wait_en(gap);
        @(posedge clk); #1;
        rst = 1'b1; dm_req = 1'b0;
        done0 = n_done;
        @(posedge clk); #1;
        rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'h5555;
        m_if_data = 16'h0; m_dm_rdata = 16'h0;
        @(posedge clk); #1;
        mem_done = 1'b0; mem_rdata = 16'h0;
        @(negedge clk);
        check_all_zero("midrst");
        check("midrst_no_done", 16'(n_done), 16'(done0));
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0080;
        push_txn(1'b0, 1'b0, 16'h0080, 16'h0, 16'h8080, 1'b1);
        serve(1'b0, 16'h8080, 0, 1'b0, gap);

        // Timeout: no mem_done ever arrives, so ERR follows busy cycle 3 and err is sticky.
        if_req = 1'b1; if_addr = 16'h0090;
        push_txn(1'b0, 1'b0, 16'h0090, 16'h0, 16'h0, 1'b0);
        wait_en(gap);
        repeat (3) @(negedge clk);
        check("err_before_timeout", {15'h0, err}, 16'h0);
        @(negedge clk);
        check("err_after_timeout", {15'h0, err}, 16'h1);
        issue0 = n_issue; done0 = n_done;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0A00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            mem_done = i[0];
            mem_rdata = 16'hEEEE;
        end
        mem_done = 1'b0;
        @(negedge clk);
        check("err_no_issue", 16'(n_issue), 16'(issue0));
        check("err_no_done", 16'(n_done), 16'(done0));
        check("err_sticky", {15'h0, err}, 16'h1);
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared_by_rst", {15'h0, err}, 16'h0);

        check("issue_queue_drained", 16'(q_issue.size()), 16'h0);
        check("cmpl_queue_drained", 16'(q_cmpl.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, max busy cycles awaiting mem_done; legal range 1..15.
REQ-002 clk  in  1  processor clock; all state changes on posedge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 if_req  in  1  fetch request; level, held until if_done.
REQ-005 if_addr  in  16  fetch address.
REQ-006 dm_req  in  1  data request (decoder MemEnable); level, held until dm_done.
REQ-007 dm_wr  in  1  1=write, 0=read (decoder MemWr).
REQ-008 dm_addr, dm_wdata  in  16 each  data address / store data.
REQ-009 halt  in  1  decoded Halt; blocks new fetch grants.
REQ-010 mem_done  in  1  memory completion strobe.
REQ-011 mem_rdata  in  16  memory read data, valid with mem_done.
REQ-012 mem_en, mem_wr  out  1 each  memory issue strobe / write select.
REQ-013 mem_addr, mem_wdata  out  16 each  latched transaction address / store data.
REQ-014 if_done, dm_done  out  1 each  one-cycle completion pulses.
REQ-015 if_data, dm_rdata  out  16 each  returned read data.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 States SHALL be IDLE, BUSY_IF, BUSY_DM, RESP, ERR; all outputs registered.
REQ-018 IDLE: dm_req=1 and if_req=1 -> grant DM (fixed priority); only one request -> grant it; if_req SHALL be ignored while halt=1.
REQ-019 On grant edge: latch addr/wdata/wr (mem_wr=0 for fetch), go BUSY_x, mem_en=1 for exactly the first BUSY cycle (busy cycle 0).
REQ-020 mem_addr/mem_wdata/mem_wr SHALL hold latched values through BUSY and RESP.
REQ-021 mem_done sampled in busy cycles 0..TIMEOUT-1 completes; mem_done in IDLE/RESP/ERR ignored.
REQ-022 Completion edge: go RESP; BUSY_IF -> if_data<=mem_rdata, if_done=1; BUSY_DM read -> dm_rdata<=mem_rdata, dm_done=1; DM write -> dm_done=1, dm_rdata unchanged.
REQ-023 RESP lasts exactly one cycle, then IDLE; requests not sampled in RESP (one-cycle bubble, min 3 cycles per transaction).
REQ-024 4-bit wait counter SHALL clear on grant, increment each busy cycle without mem_done.
REQ-025 No mem_done by end of busy cycle TIMEOUT-1 -> ERR, err=1; ERR grants nothing, no done pulses, exits only on rst.
REQ-026 halt rising during BUSY_IF SHALL NOT abort the fetch; it completes normally.
REQ-027 if_data/dm_rdata SHALL hold last value until next matching read completion.

Reset
REQ-028 rst=1 at posedge -> state IDLE, counter 0, all outputs 0 incl. err and data regs; in-flight transaction discarded.
REQ-029 rst asserted mid-BUSY SHALL produce no done pulse; a later stray mem_done SHALL be ignored.

Configuration
REQ-030 Macro MEM_ARB_RR_EN defined: tie (both requesting, halt=0) SHALL grant the requester not served last; last-served flag resets to IF, so first tie grants DM.
REQ-031 Macro undefined: fixed DM-over-IF priority per REQ-018; no last-served flag.

Verification
REQ-032 Fetch: if_req=1, if_addr=0x0040, mem_done in busy cycle 1 with mem_rdata=0xD123 -> mem_en one cycle, mem_addr=0x0040, mem_wr=0, if_done pulse, if_data=0xD123.
REQ-033 Tie: if_req=dm_req=1, dm_wr=1, dm_addr=0x0100, dm_wdata=0xBEEF -> DM first (mem_wr=1), dm_done, dm_rdata unchanged; fetch issued after RESP+IDLE; with MEM_ARB_RR_EN second tie grants IF.
REQ-034 Halt: halt=1, if_req=1 for 20 cycles -> no mem_en; dm_req=1 read during halt -> served normally.
REQ-035 Timeout (TIMEOUT=4): grant, mem_done never -> ERR after busy cycle 3, err=1 sticky; later requests and mem_done ignored until rst.
REQ-036 Reset mid-op: rst in busy cycle 1 of DM read, mem_done next cycle -> no dm_done, all outputs 0, IDLE.
